// File: rtl/mips_fetch_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
// Shared types for the instruction fetch stage: datapath word width, the
// fetch state machine encoding and the prefetch FIFO entry layout.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // IDLE: no request outstanding
    // WAIT: request outstanding, its data will be kept
    // DROP: request outstanding, its data will be discarded (redirected)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Prefetch buffer holding {pc, instr} pairs between instruction memory and
// the decoder. DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i, pc_i, instr_i  write one entry
//   pop_i                  drop the head entry (ignored when empty)
//   flush_i                empty the buffer; wins over push/pop
//   count_o                number of buffered entries (0..DEPTH)
//   valid_o, head_pc_o,
//   head_instr_o           head entry, zeroed when the buffer is empty
// -----------------------------------------------------------------------------
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [WORD_W-1:0]       pc_i,
    input  logic [WORD_W-1:0]       instr_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    valid_o,
    output logic [WORD_W-1:0]       head_pc_o,
    output logic [WORD_W-1:0]       head_instr_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;
    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     headEntry;
    logic             popEn, pushEn;

    // A pop frees a slot in the same cycle, so a full buffer may still accept
    // a push when it is also being popped.
    assign popEn  = pop_i && (count_q != '0);
    assign pushEn = push_i && ((count_q != CNT_W'(DEPTH)) || popEn);

    // Pointer and occupancy bookkeeping; flush clears everything at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (popEn)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({pushEn, popEn})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clk_i) begin
        if (pushEn && !flush_i) begin
            mem_q[wrPtr_q] <= '{pc: pc_i, instr: instr_i};
        end
    end

    assign headEntry    = mem_q[rdPtr_q];
    assign count_o      = count_q;
    assign valid_o      = (count_q != '0);
    assign head_pc_o    = valid_o ? headEntry.pc    : '0;
    assign head_instr_o = valid_o ? headEntry.instr : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage in front of the single-cycle MIPS core. Owns the fetch PC,
// issues one word-addressed request at a time to instruction memory, buffers
// returned words in a prefetch FIFO and hands them to the decoder.
// Ports:
//   clock, reset_n             clock, asynchronous active-low reset
//   imem_req, imem_addr        registered request / word address to memory
//   imem_ack, imem_rdata       memory accepts and returns data this cycle
//   redirect, redirect_pc      flush and restart fetch at redirect_pc
//   ins_valid, ins_data,
//   ins_pc, ins_ready          instruction handoff to the decoder
// -----------------------------------------------------------------------------
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    input  logic        ins_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetchPc_q, fetchPc_d;
    logic [31:0]      imemAddr_q, imemAddr_d;
    logic             imemReq_q;
    logic             push, pop;
    logic [CNT_W-1:0] fifoCount;
    logic [CNT_W-1:0] countAfterPush;
    logic             hasRoom, roomAfterPush;

    assign pop            = ins_valid && ins_ready;
    assign hasRoom        = fifoCount < CNT_W'(DEPTH);
    assign countAfterPush = fifoCount + CNT_W'(1) - CNT_W'(pop);
    assign roomAfterPush  = countAfterPush < CNT_W'(DEPTH);

    // State register plus the registered request outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetchPc_q  <= RESET_PC;
            imemAddr_q <= RESET_PC;
            imemReq_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetchPc_q  <= fetchPc_d;
            imemAddr_q <= imemAddr_d;
            imemReq_q  <= (state_d != IDLE);
        end
    end

    // Next-state logic. A request that is already outstanding must still
    // complete after a redirect, hence DROP rather than going straight to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!redirect && hasRoom) state_d = WAIT;
            WAIT: begin
                if (redirect)      state_d = imem_ack ? IDLE : DROP;
                else if (imem_ack) state_d = roomAfterPush ? WAIT : IDLE;
            end
            DROP: if (imem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath side of the FSM: fetch PC, request address and FIFO push.
    // The request address only moves when a new request starts, so it is
    // stable for the whole life of a request.
    always_comb begin
        fetchPc_d  = fetchPc_q;
        imemAddr_d = imemAddr_q;
        push       = 1'b0;
        if (redirect) fetchPc_d = redirect_pc;
        case (state_q)
            IDLE: if (!redirect && hasRoom) imemAddr_d = fetchPc_q;
            WAIT: begin
                if (!redirect && imem_ack) begin
                    push      = 1'b1;
                    fetchPc_d = fetchPc_q + 32'd1;
                    if (roomAfterPush) imemAddr_d = fetchPc_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    assign imem_req  = imemReq_q;
    assign imem_addr = imemAddr_q;

    // Redirect flushes the buffer, which also swallows any same-cycle pop.
    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i        (clock),
        .rst_ni       (reset_n),
        .push_i       (push),
        .pc_i         (fetchPc_q),
        .instr_i      (imem_rdata),
        .pop_i        (pop),
        .flush_i      (redirect),
        .count_o      (fifoCount),
        .valid_o      (ins_valid),
        .head_pc_o    (ins_pc),
        .head_instr_o (ins_data)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Table-driven bench for the fetch stage: each row gives one cycle's inputs
// and the outputs expected during that cycle, plus a hand-written sequence
// for an asynchronous reset in the middle of a request.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_ready;

    int testsRun;
    int testsFailed;

    typedef struct {
        bit          rst;
        bit          ack;
        bit          redir;
        logic [31:0] redirPc;
        bit          ready;
        bit          expReq;
        logic [31:0] expAddr;
        bit          expValid;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins_valid   (ins_valid),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Safety net so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run still active at limit 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] instrOf(logic [31:0] pc);
        return pc ^ 32'h8C00_0000;
    endfunction

    function automatic void addRow(bit rst, bit ack, bit redir, logic [31:0] rpc,
                                   bit ready, bit eReq, logic [31:0] eAddr,
                                   bit eValid, logic [31:0] ePc);
        vecs.push_back('{rst, ack, redir, rpc, ready, eReq, eAddr, eValid, ePc});
    endfunction

    task automatic compare(string name, logic [31:0] actual, logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(string tag, bit eReq, logic [31:0] eAddr,
                               bit eValid, logic [31:0] ePc);
        logic [31:0] eData;
        eData = eValid ? instrOf(ePc) : 32'h0;
        compare({tag, " imem_req"},  {31'b0, imem_req},  {31'b0, eReq});
        compare({tag, " imem_addr"}, imem_addr,          eAddr);
        compare({tag, " ins_valid"}, {31'b0, ins_valid}, {31'b0, eValid});
        compare({tag, " ins_pc"},    ins_pc,             eValid ? ePc : 32'h0);
        compare({tag, " ins_data"},  ins_data,           eData);
    endtask

    // Inputs are driven just after the falling edge; the memory model answers
    // with the word for whatever address is currently requested.
    task automatic applyStimulus(vec_t v);
        imem_ack    = v.ack;
        redirect    = v.redir;
        redirect_pc = v.redirPc;
        ins_ready   = v.ready;
        imem_rdata  = v.ack ? instrOf(imem_addr) : 32'hDEAD_BEEF;
    endtask

    // Holds reset for one full cycle and releases it on a falling edge.
    task automatic doReset();
        @(negedge clock);
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ins_ready   = 1'b0;
        imem_rdata  = 32'h0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ins_ready   = 1'b0;
        imem_rdata  = 32'h0;

        //     rst ack red rpc           rdy  req addr          val pc
        // Zero-wait streaming with the consumer always ready.
        addRow(1, 1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h1,        1, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h2,        1, 32'h1);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h3,        1, 32'h2);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h4,        1, 32'h3);
        // Consumer stalled: four pushes fill the buffer, request stops,
        // then fetch resumes at PC 4 once popping starts.
        addRow(1, 1, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        0,   1, 32'h1,        1, 32'h0);
        addRow(0, 1, 0, 32'h0,        0,   1, 32'h2,        1, 32'h0);
        addRow(0, 1, 0, 32'h0,        0,   1, 32'h3,        1, 32'h0);
        addRow(0, 1, 0, 32'h0,        0,   0, 32'h3,        1, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   0, 32'h3,        1, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   0, 32'h3,        1, 32'h1);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h4,        1, 32'h2);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h5,        1, 32'h3);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h6,        1, 32'h4);
        // Slow memory, redirect during the first wait cycle.
        addRow(1, 0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0);
        addRow(0, 0, 1, 32'h40,       1,   1, 32'h0,        0, 32'h0);
        addRow(0, 0, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0);
        addRow(0, 0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h40,       0, 32'h0);
        addRow(0, 0, 0, 32'h0,        1,   1, 32'h41,       1, 32'h40);
        addRow(0, 0, 0, 32'h0,        1,   1, 32'h41,       0, 32'h0);
        // Redirect together with ack and pop while two entries are buffered.
        addRow(1, 1, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        0,   1, 32'h1,        1, 32'h0);
        addRow(0, 1, 1, 32'h100,      1,   1, 32'h2,        1, 32'h0);
        addRow(0, 0, 0, 32'h0,        1,   0, 32'h2,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h100,      0, 32'h0);
        addRow(0, 0, 0, 32'h0,        0,   1, 32'h101,      1, 32'h100);
        // PC wrap-around from the top of the address space.
        addRow(1, 1, 1, 32'hFFFF_FFFF, 1,  0, 32'h0,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'hFFFF_FFFF, 0, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h0,        1, 32'hFFFF_FFFF);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h1,        1, 32'h0);
        addRow(0, 1, 0, 32'h0,        1,   1, 32'h2,        1, 32'h1);
        // Build up some state ahead of the mid-request reset.
        addRow(1, 0, 1, 32'h20,       0,   0, 32'h0,        0, 32'h0);
        addRow(0, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0);
        addRow(0, 1, 0, 32'h0,        0,   1, 32'h20,       0, 32'h0);
        addRow(0, 0, 0, 32'h0,        0,   1, 32'h21,       1, 32'h20);

        foreach (vecs[i]) begin
            if (vecs[i].rst) doReset();
            else             @(negedge clock);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row %0d", i), vecs[i].expReq, vecs[i].expAddr,
                        vecs[i].expValid, vecs[i].expPc);
        end

        // Request to 0x21 is outstanding with one entry buffered; the ack
        // arrives while reset is asserted between clock edges.
        @(negedge clock);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clock);
        #1;
        checkOutput("reset held", 1'b0, 32'h0, 1'b0, 32'h0);
        // Release with the stale ack still high: IDLE must not push it.
        reset_n = 1'b1;
        #1;
        checkOutput("reset released", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clock);
        imem_ack = 1'b0;
        #1;
        checkOutput("late ack ignored", 1'b1, 32'h0, 1'b0, 32'h0);
        @(negedge clock);
        #1;
        checkOutput("no push after reset", 1'b1, 32'h0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage directly upstream of the single-cycle MIPS core. It owns the fetch program counter and issues word-addressed requests to an instruction memory over a req/ack handshake. Returned instructions are buffered in a small prefetch FIFO and handed to the core/decoder over a valid/ready interface. A redirect input from the core (jump, jump-register, taken branch) flushes buffered and in-flight instructions and restarts fetch at the new PC.

## Interface
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 32'h0, fetch PC after reset (word address)
- clock  input  1  sole clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- imem_req  output  1  request to instruction memory; registered
- imem_addr  output  32  word address of the request; registered, stable while imem_req=1
- imem_ack  input  1  memory accepted the request and returns data this cycle; may be asserted in the first cycle of imem_req (zero-wait)
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- redirect  input  1  one-cycle pulse: discard all fetched/in-flight instructions
- redirect_pc  input  32  new fetch PC, sampled when redirect=1
- ins_valid  output  1  FIFO head holds a valid instruction
- ins_data  output  32  FIFO head instruction; 0 when ins_valid=0
- ins_pc  output  32  word address of ins_data; 0 when ins_valid=0
- ins_ready  input  1  consumer takes the head this cycle (pop when ins_valid & ins_ready)

## Operation
- State machine, states IDLE, WAIT, DROP; imem_req=1 exactly in WAIT and DROP.
- IDLE: if count < DEPTH and no redirect → WAIT, imem_addr <= fetch_pc.
- WAIT, imem_ack=1, no redirect: push {fetch_pc, imem_rdata}; fetch_pc += 1; count_next = count + 1 − pop. If count_next < DEPTH, stay WAIT with imem_addr <= fetch_pc+1 (back-to-back); else → IDLE.
- WAIT, redirect=1, imem_ack=0: → DROP; fetch_pc <= redirect_pc; imem_addr unchanged (request must complete).
- WAIT, redirect=1, imem_ack=1: ack data discarded; fetch_pc <= redirect_pc; → IDLE.
- DROP: hold imem_req; on imem_ack discard data → IDLE. A further redirect in DROP overwrites fetch_pc only.
- IDLE, redirect=1: fetch_pc <= redirect_pc; stay IDLE.
- Redirect in any state: FIFO flushed (pointers and count to 0) on that edge; a pop in the same cycle is absorbed by the flush; no push that cycle.
- Push and pop in the same cycle: count unchanged; pop of a full FIFO with an ack is legal.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFF + 1 wraps to 0. FIFO pointers log2(DEPTH) bits, wrap naturally.
- Reset (any time, including mid-request): state IDLE, fetch_pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, FIFO empty, ins_valid=0, ins_data=0, ins_pc=0. Any ack arriving after reset is ignored (IDLE does not push).

## Timing
- Redirect at edge N → imem_req=1, imem_addr=redirect_pc from cycle N+1 (via IDLE at cycle N) → with zero-wait ack, ins_valid=1 at cycle N+2.
- Back-to-back zero-wait acks sustain one instruction per cycle while the consumer pops every cycle.
- ins_valid/ins_data/ins_pc are combinational from FIFO state only; no combinational path from imem_* or ins_ready to outputs.
- At most one outstanding request; imem_addr never changes while imem_req=1 and imem_ack=0.

## Structure
- Package mips_fetch_pkg: fetch state enum {IDLE, WAIT, DROP}, WORD_W=32, fetch entry struct {pc, instr}.
- One sub-module: fetch_fifo (DEPTH entries, push/pop/flush, count, head outputs zeroed when empty).

## Test plan
- Reset release, ack always 1, ins_ready=1 → imem_addr 0,1,2,… one per cycle; ins_pc 0,1,2,… from cycle 2.
- ins_ready=0, zero-wait ack → exactly 4 pushes (PC 0–3), imem_req drops, ins_valid stays 1 with ins_pc=0; set ins_ready=1 → fetch resumes at PC 4.
- Ack delayed 3 cycles, redirect to 32'h40 in wait cycle 1 → req held on old addr until ack, data discarded, next request addr 32'h40, first ins_pc 32'h40.
- Redirect same cycle as ack and as a pop with 2 entries buffered → FIFO empty next cycle, next ins_pc = redirect_pc.
- Redirect to 32'hFFFF_FFFF → ins_pc sequence FFFF_FFFF, 0, 1.
- reset_n low mid-WAIT with ack pending → outputs return to reset values immediately; late ack causes no push.
